// File: rtl/tt_bin_clock_v2_pkg.sv
// Shared types and constants for the binary alarm clock: field limits,
// alarm FSM states and the 12/24 h hour display mapping.
package tt_bin_clock_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } alarm_state_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // 12 h mode shows midnight and noon as 12.
  function automatic logic [4:0] hour_disp(input logic [4:0] h, input logic mode_24);
    if (mode_24) return h;
    if (h == 5'd0 || h == 5'd12) return 5'd12;
    return (h > 5'd12) ? h - 5'd12 : h;
  endfunction

endpackage

// File: rtl/tt_bin_clock_v2_if.sv
// User controls and display outputs of the binary alarm clock, bundled
// so the clock core and its driver share one port.
interface tt_bin_clock_v2_if;

  logic       time_set;
  logic       alarm_set;
  logic       id_switch;
  logic       hour_id;
  logic       minute_id;
  logic       seconds_id;
  logic       mode_24;
  logic       alarm_en;
  logic [4:0] hour_out;
  logic [5:0] minute_out;
  logic [5:0] seconds_out;
  logic       pm_out;
  logic       alarm_out;
  logic       tick_o;

  modport master (
    output time_set, alarm_set, id_switch, hour_id, minute_id, seconds_id,
           mode_24, alarm_en,
    input  hour_out, minute_out, seconds_out, pm_out, alarm_out, tick_o
  );

  modport slave (
    input  time_set, alarm_set, id_switch, hour_id, minute_id, seconds_id,
           mode_24, alarm_en,
    output hour_out, minute_out, seconds_out, pm_out, alarm_out, tick_o
  );

endinterface

// File: rtl/tt_bin_clock_v2_modcnt.sv
// Wrap-around up/down counter 0..MAX for one clock field; carry flags an
// increment that wraps MAX -> 0.
module tt_bin_clock_modcnt #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value_o,
  output logic         carry
);

  logic [W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (inc) begin
      val_d = (val_q == W'(MAX)) ? '0 : val_q + W'(1);
    end else if (dec) begin
      val_d = (val_q == '0) ? W'(MAX) : val_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) val_q <= '0;
    else         val_q <= val_d;
  end

  assign carry   = inc && (val_q == W'(MAX));
  assign value_o = val_q;

endmodule

// File: rtl/tt_bin_clock_v2.sv
// Binary 24 h clock with 1 Hz prescaler, button-driven time/alarm adjust,
// 12/24 h display mapping and a self-expiring alarm ring.
module tt_bin_clock_v2
  import tt_bin_clock_pkg::*;
#(
  parameter int CLK_HZ  = 100,
  parameter int ALARM_S = 30,
  parameter int CNT_W   = $clog2(CLK_HZ)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  tt_bin_clock_v2_if.slave bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  logic [2:0] btn_in, btn_q, rise;
  logic       armed_q;
  logic       any_rise;

  alarm_state_e state_q;
  logic [7:0]   ring_cnt_q;
  logic         alarm_q;

  logic adj_en, time_adj, alarm_adj, up;
  logic sel_s, sel_m, sel_h, sel_am, sel_ah;

  logic [5:0] sec_q, min_q, am_q;
  logic [4:0] hr_q, ah_q;
  logic       sec_carry, min_carry, hr_carry;
  logic       am_carry_unused, ah_carry_unused;
  logic       alarm_hit, alarm_view;
  logic [4:0] disp_h;

  assign tick = (cnt_q == CNT_W'(CLK_HZ - 1)) && !bus.time_set;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (bus.time_set || tick) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // armed_q blanks the first cycle after reset so a button held through
  // reset is not mistaken for a fresh press.
  assign btn_in   = {bus.hour_id, bus.minute_id, bus.seconds_id};
  assign rise     = btn_in & ~btn_q & {3{armed_q}};
  assign any_rise = |rise;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn_in;
      armed_q <= 1'b1;
    end
  end

  // A press while ringing only dismisses, it never adjusts.
  assign adj_en    = (state_q == IDLE);
  assign time_adj  = adj_en && bus.time_set;
  assign alarm_adj = adj_en && !bus.time_set && bus.alarm_set;
  assign up        = bus.id_switch;

  assign sel_s  = rise[0];
  assign sel_m  = rise[1] && !rise[0];
  assign sel_h  = rise[2] && !rise[1] && !rise[0];
  assign sel_am = rise[1];
  assign sel_ah = rise[2] && !rise[1];

  tt_bin_clock_modcnt #(.MAX(SEC_MAX), .W(6)) u_sec (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (tick | (time_adj & sel_s & up)),
    .dec     (time_adj & sel_s & ~up),
    .value_o (sec_q),
    .carry   (sec_carry)
  );

  tt_bin_clock_modcnt #(.MAX(MIN_MAX), .W(6)) u_min (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     ((tick & sec_carry) | (time_adj & sel_m & up)),
    .dec     (time_adj & sel_m & ~up),
    .value_o (min_q),
    .carry   (min_carry)
  );

  tt_bin_clock_modcnt #(.MAX(HR_MAX), .W(5)) u_hr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     ((tick & sec_carry & min_carry) | (time_adj & sel_h & up)),
    .dec     (time_adj & sel_h & ~up),
    .value_o (hr_q),
    .carry   (hr_carry)
  );

  tt_bin_clock_modcnt #(.MAX(MIN_MAX), .W(6)) u_alarm_m (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (alarm_adj & sel_am & up),
    .dec     (alarm_adj & sel_am & ~up),
    .value_o (am_q),
    .carry   (am_carry_unused)
  );

  tt_bin_clock_modcnt #(.MAX(HR_MAX), .W(5)) u_alarm_h (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (alarm_adj & sel_ah & up),
    .dec     (alarm_adj & sel_ah & ~up),
    .value_o (ah_q),
    .carry   (ah_carry_unused)
  );

  // Match against the time this tick produces, i.e. alarm_h:alarm_m:00.
  always_comb begin
    alarm_hit = 1'b0;
    if (tick && sec_carry) begin
      if (!min_carry)     alarm_hit = (am_q == min_q + 6'd1) && (ah_q == hr_q);
      else if (!hr_carry) alarm_hit = (am_q == '0) && (ah_q == hr_q + 5'd1);
      else                alarm_hit = (am_q == '0) && (ah_q == '0);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      alarm_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_hit && bus.alarm_en) begin
            state_q    <= RING;
            ring_cnt_q <= '0;
            alarm_q    <= 1'b1;
          end
        end
        RING: begin
          if (any_rise || !bus.alarm_en || bus.time_set ||
              (tick && ring_cnt_q == 8'(ALARM_S - 1))) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end else if (tick) begin
            ring_cnt_q <= ring_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_view = !bus.time_set && bus.alarm_set;
  assign disp_h     = alarm_view ? ah_q : hr_q;

  assign bus.hour_out    = hour_disp(disp_h, bus.mode_24);
  assign bus.minute_out  = alarm_view ? am_q : min_q;
  assign bus.seconds_out = alarm_view ? 6'd0 : sec_q;
  assign bus.pm_out      = (hr_q >= 5'd12);
  assign bus.alarm_out   = alarm_q;
  assign bus.tick_o      = tick;

endmodule

// File: doc/tt_bin_clock_v2.md
TT_BIN_CLOCK_V2 -- requirements
Module: tt_bin_clock_v2

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100: input clock cycles per second, legal range 2..65535.
REQ-002 SHALL have parameter ALARM_S, default 30: maximum alarm ring duration in seconds, legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default $clog2(CLK_HZ): prescaler width.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 time_set  input  1  1 = adjust time, prescaler held; 0 = run.
REQ-007 alarm_set  input  1  1 (with time_set=0) = adjust alarm registers while time runs.
REQ-008 id_switch  input  1  1 = increment, 0 = decrement.
REQ-009 hour_id, minute_id, seconds_id  input  1 each  adjust buttons, level inputs, edge-detected internally.
REQ-010 mode_24  input  1  1 = 24 h display, 0 = 12 h display.
REQ-011 alarm_en  input  1  arms alarm.
REQ-012 hour_out  output  5  displayed hour; minute_out  output  6; seconds_out  output  6.
REQ-013 pm_out  output  1  internal hour >= 12, both modes; alarm_out  output  1  ringing; tick_o  output  1  one-cycle 1 Hz pulse.

Function
REQ-014 Internal time SHALL be 24 h binary: hours 0..23, minutes 0..59, seconds 0..59; alarm registers alarm_h 0..23, alarm_m 0..59.
REQ-015 Prescaler SHALL count 0..CLK_HZ-1 when time_set=0; tick_o = (cnt==CLK_HZ-1) && !time_set, combinational.
REQ-016 On the tick edge seconds SHALL increment; at 59 -> 0 with minute carry; minutes 59 -> 0 with hour carry; hours 23 -> 0; all updates in the same edge.
REQ-017 While time_set=1 the prescaler SHALL be held at 0, so the first tick after release occurs CLK_HZ cycles later.
REQ-018 Each *_id SHALL be registered; one adjust step SHALL occur only in the cycle after a 0->1 transition, never per held cycle.
REQ-019 Simultaneous rising edges SHALL apply one step only, priority seconds > minutes > hours.
REQ-020 Adjust steps SHALL be ±1 with wrap (59<->0, 23<->0) and no carry between fields.
REQ-021 Target: time fields when time_set=1; alarm_h/alarm_m when time_set=0 and alarm_set=1 (seconds_id ignored); otherwise edges ignored except dismiss (REQ-025). time_set wins over alarm_set.
REQ-022 Display: mode_24=1 -> hour_out = hours; mode_24=0 -> hour_out = 12 for hours 0 and 12, else hours mod 12. alarm_set=1 with time_set=0 SHALL show alarm_h/alarm_m (same mapping) with seconds_out = 0.
REQ-023 mode_24 SHALL affect display only, never stored time.
REQ-024 Alarm FSM states IDLE, RING. IDLE->RING on a tick edge whose resulting time equals alarm_h:alarm_m:00 while alarm_en=1.
REQ-025 RING->IDLE when any of: ALARM_S ticks elapsed in RING, alarm_en=0, any *_id rising edge (dismiss), or time_set=1; exit takes effect the next edge.
REQ-026 alarm_out SHALL be 1 exactly while in RING; a dismiss edge in RING SHALL NOT also adjust any field.
REQ-027 Time adjusted onto the alarm value while time_set=1 SHALL NOT trigger the alarm.

Reset
REQ-028 reset_i SHALL asynchronously force: prescaler 0, time 00:00:00, alarm 00:00, FSM IDLE, button registers 0.
REQ-029 Outputs under reset: hour_out = 0 (mode_24=1) or 12 (mode_24=0), minute_out 0, seconds_out 0, pm_out 0, alarm_out 0, tick_o 0.
REQ-030 Reset mid-RING or mid-adjust SHALL abort with no residual step after release.

Structure
REQ-031 Package tt_bin_clock_pkg SHALL hold the FSM state enum and constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
REQ-032 Wrap up/down counter SHALL be sub-module tt_bin_clock_modcnt (parameters MAX, W; inputs inc, dec, carry out), instanced for every field.

Verification (CLK_HZ=4, ALARM_S=3)
REQ-033 Reset, run 4*3600 cycles -> 01:00:00, tick_o pulses 3600, each one cycle wide.
REQ-034 Set 23:59:59, release time_set, 4 cycles -> 00:00:00, pm_out 1->0, mode_24=0 hour_out 11->12.
REQ-035 time_set=1, id_switch=0, seconds_id held high 10 cycles at 00 -> seconds 59 (one step); minute and hour edges same cycle -> minutes unchanged.
REQ-036 Alarm 07:30, alarm_en=1, time 07:29:59 -> alarm_out rises at 07:30:00, falls after 3 ticks; repeat with hour_id edge at 1 tick -> falls next edge, hours unchanged.
REQ-037 Assert reset_i mid-RING and during held seconds_id -> all REQ-029 values immediately; no step after release.
